conv1_calc: RTL and testbench
=============================

CONV1_CALC -- requirements
Module: conv1_calc

Interface
REQ-001 Parameter WIDTH, 28, input image width in pixels.
REQ-002 Parameter HEIGHT, 28, input image height in pixels.
REQ-003 Parameter NUM_FILT, 3, number of 3x3 filters evaluated in parallel.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  3x3 window on pixel_0..pixel_8 is valid this cycle.
REQ-007 pixel_0 .. pixel_8  input  1 each  binary window, row-major, pixel_0 top-left.
REQ-008 w_load  input  1  w_data carries the next weight word this cycle.
REQ-009 w_data  input  8  signed weight or bias word.
REQ-010 w_ready  output  1  all NUM_FILT*10 words loaded; block is in RUN.
REQ-011 valid_out  output  1  conv_out valid this cycle.
REQ-012 conv_out  output  NUM_FILT*13  signed results, filter f at bits [13f+12:13f].
REQ-013 frame_done  output  1  one-cycle pulse on the last output of a frame.

Function
REQ-014 The block SHALL have two states: LOAD (after reset) and RUN.
REQ-015 In LOAD, each cycle with w_load=1 SHALL store w_data at a word index counting 0..NUM_FILT*10-1, in the order: filter 0 w0..w8, bias0, filter 1 w0..w8, bias1, and so on.
REQ-016 Storing word NUM_FILT*10-1 SHALL move the block to RUN, with w_ready=1 from the next cycle.
REQ-017 In RUN, w_load SHALL be ignored; only rst returns the block to LOAD.
REQ-018 valid_in SHALL be ignored in LOAD, including the cycle in which the last weight word is stored.
REQ-019 In RUN, a window SHALL be accepted on every cycle with valid_in=1; back-to-back windows SHALL be accepted at full rate, with no stall.
REQ-020 Stage 1 SHALL register, per filter, partial sums of the weights wk where pixel_k=1 (zero where pixel_k=0).
REQ-021 Stage 2 SHALL register the final sum plus bias into conv_out and assert valid_out.
REQ-022 Latency: valid_out SHALL be 1 exactly 2 cycles after the accepting valid_in edge.
REQ-023 Arithmetic SHALL be signed at full precision in 13 bits, with no saturation (range -1280..+1270).
REQ-024 conv_out SHALL hold its last value while valid_out=0.
REQ-025 An output counter SHALL count valid_out cycles 0..(WIDTH-2)*(HEIGHT-2)-1.
REQ-026 frame_done SHALL be 1 in the same cycle as the (WIDTH-2)*(HEIGHT-2)th valid_out (676 at defaults); the counter SHALL then wrap to 0.

Reset
REQ-027 rst=1 SHALL immediately clear all of the following: state=LOAD, word index=0, all weights and biases=0, pipeline valids=0, conv_out=0, valid_out=0, w_ready=0, frame_done=0, output counter=0.
REQ-028 A reset mid-frame SHALL discard in-flight windows, and the next frame SHALL require a full reload.

Configuration
REQ-029 With macro CONV1_RELU_EN defined, stage 2 SHALL clamp negative results to 0 before registering conv_out.
REQ-030 Without CONV1_RELU_EN, conv_out SHALL carry the raw signed result.

Verification
REQ-031 Load all weights=1 and biases=0, then apply one window with all pixels=1 -> every filter outputs 9, with valid_out exactly 2 cycles later.
REQ-032 Filter 0 weights wk=k-4, bias0=-3; window with only pixel_0 and pixel_8=1 -> filter 0 outputs -3 without CONV1_RELU_EN and 0 with it.
REQ-033 All weights and biases=-128, all pixels=1 -> every filter outputs -1280 (no overflow, without RELU).
REQ-034 Stream 677 consecutive windows -> 677 valid_out; frame_done only on the 676th; no frame_done on the 677th.
REQ-035 Load 15 words, then drive valid_in for 10 cycles -> no valid_out and w_ready=0 throughout.
REQ-036 Assert rst after 100 outputs -> all outputs 0 asynchronously; after reload and a new stream, frame_done occurs on output 676 of the new stream.

Source files
------------

// File: rtl/conv1_calc.sv
// conv1_calc: three-by-three binary-window convolution over NUM_FILT filters.
// The block loads NUM_FILT*10 signed weight/bias words, then runs a two-stage
// pipeline. Stage 1 holds per-row partial sums and stage 2 holds sum plus bias.
// Optional macro CONV1_RELU_EN clamps negative results to zero in stage 2.
module conv1_calc #(
   parameter int unsigned WIDTH    = 28,
   parameter int unsigned HEIGHT   = 28,
   parameter int unsigned NUM_FILT = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic                     pixel_0,
   input  logic                     pixel_1,
   input  logic                     pixel_2,
   input  logic                     pixel_3,
   input  logic                     pixel_4,
   input  logic                     pixel_5,
   input  logic                     pixel_6,
   input  logic                     pixel_7,
   input  logic                     pixel_8,
   input  logic                     w_load,
   input  logic [7:0]               w_data,
   output logic                     w_ready,
   output logic                     valid_out,
   output logic [NUM_FILT*13-1:0]   conv_out,
   output logic                     frame_done
);

   localparam int unsigned OUT_W  = 13;
   localparam int unsigned NWORDS = NUM_FILT * 10;
   localparam int unsigned IDX_W  = $clog2(NWORDS);
   localparam int unsigned FRAME  = (WIDTH - 2) * (HEIGHT - 2);
   localparam int unsigned CNT_W  = $clog2(FRAME + 1);

   typedef enum logic {LOAD, RUN} state_t;

   state_t                             state_q, state_d;
   logic                               store_c;
   logic                               accept_c;
   logic [IDX_W-1:0]                   w_idx_q;
   logic [NWORDS-1:0][7:0]             wmem_q;
   logic [8:0]                         pix_c;
   wire  [NUM_FILT-1:0][2:0][OUT_W-1:0] psum_d;
   logic [NUM_FILT-1:0][2:0][OUT_W-1:0] psum_q;
   logic                               v1_q;
   wire  [NUM_FILT-1:0][OUT_W-1:0]     res_c;
   logic [CNT_W-1:0]                   out_cnt_q;

   assign pix_c    = {pixel_8, pixel_7, pixel_6, pixel_5, pixel_4,
                      pixel_3, pixel_2, pixel_1, pixel_0};
   assign accept_c = valid_in && (state_q == RUN);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   // Next-state: leave LOAD once the final weight word is stored
   always_comb begin
      state_d = state_q;
      store_c = 1'b0;
      case (state_q)
         LOAD: begin
            if (w_load) begin
               store_c = 1'b1;
               if (w_idx_q == IDX_W'(NWORDS - 1)) state_d = RUN;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = LOAD;
      endcase
   end

   // Weight/bias storage, word index and ready flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_idx_q <= '0;
         wmem_q  <= '0;
         w_ready <= 1'b0;
      end else begin
         if (store_c) begin
            wmem_q[w_idx_q] <= w_data;
            w_idx_q         <= w_idx_q + IDX_W'(1);
         end
         w_ready <= (state_d == RUN);
      end
   end

   // Per-filter row sums (stage 1 inputs) and final sum with bias (stage 2 inputs)
   for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
      for (genvar r = 0; r < 3; r++) begin : g_row
         logic signed [OUT_W-1:0] t0, t1, t2;
         assign t0 = pix_c[3*r]   ? OUT_W'($signed(wmem_q[f*10 + 3*r]))     : '0;
         assign t1 = pix_c[3*r+1] ? OUT_W'($signed(wmem_q[f*10 + 3*r + 1])) : '0;
         assign t2 = pix_c[3*r+2] ? OUT_W'($signed(wmem_q[f*10 + 3*r + 2])) : '0;
         assign psum_d[f][r] = t0 + t1 + t2;
      end

      logic signed [OUT_W-1:0] sum_c;
      assign sum_c = $signed(psum_q[f][0]) + $signed(psum_q[f][1])
                   + $signed(psum_q[f][2]) + OUT_W'($signed(wmem_q[f*10 + 9]));
`ifdef CONV1_RELU_EN
      assign res_c[f] = sum_c[OUT_W-1] ? '0 : sum_c;
`else
      assign res_c[f] = sum_c;
`endif
   end

   // Stage 1: capture row partial sums for accepted windows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q   <= 1'b0;
         psum_q <= '0;
      end else begin
         v1_q <= accept_c;
         if (accept_c) psum_q <= psum_d;
      end
   end

   // Stage 2: result register, output valid, frame counter and frame_done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         out_cnt_q  <= '0;
      end else begin
         valid_out  <= v1_q;
         frame_done <= 1'b0;
         if (v1_q) begin
            conv_out <= res_c;
            if (out_cnt_q == CNT_W'(FRAME - 1)) begin
               out_cnt_q  <= '0;
               frame_done <= 1'b1;
            end else begin
               out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_conv1_calc.sv
// tb_conv1_calc: scoreboard bench for conv1_calc; expected results are queued
// when windows are driven and popped when valid_out is seen.
module tb_conv1_calc;

   localparam int NF    = 3;
   localparam int W     = 28;
   localparam int H     = 28;
   localparam int FRAME = (W - 2) * (H - 2);
   localparam int NW    = NF * 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_in;
   logic              pixel_0, pixel_1, pixel_2, pixel_3, pixel_4;
   logic              pixel_5, pixel_6, pixel_7, pixel_8;
   logic              w_load;
   logic [7:0]        w_data;
   logic              w_ready;
   logic              valid_out;
   logic [NF*13-1:0]  conv_out;
   logic              frame_done;

   conv1_calc #(.WIDTH(W), .HEIGHT(H), .NUM_FILT(NF)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .pixel_0(pixel_0), .pixel_1(pixel_1), .pixel_2(pixel_2),
      .pixel_3(pixel_3), .pixel_4(pixel_4), .pixel_5(pixel_5),
      .pixel_6(pixel_6), .pixel_7(pixel_7), .pixel_8(pixel_8),
      .w_load(w_load), .w_data(w_data), .w_ready(w_ready),
      .valid_out(valid_out), .conv_out(conv_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               cyc;
      logic             fd;
      logic [NF*13-1:0] data;
   } exp_t;

   exp_t              sb[$];
   int                tbw[NW];
   int                total = 0;
   int                bad = 0;
   int                push_num = 0;
   bit                tb_run = 0;
   logic [NF*13-1:0]  last_out = '0;

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] model(input int f, input logic [8:0] p);
      int s;
      s = tbw[f*10 + 9];
      for (int k = 0; k < 9; k++) if (p[k]) s += tbw[f*10 + k];
`ifdef CONV1_RELU_EN
      if (s < 0) s = 0;
`endif
      return 13'(s);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [8:0] p);
      {pixel_8, pixel_7, pixel_6, pixel_5, pixel_4,
       pixel_3, pixel_2, pixel_1, pixel_0} = p;
   endtask

   task automatic send(input logic [8:0] p);
      exp_t e;
      step();
      valid_in = 1'b1;
      set_pix(p);
      if (tb_run) begin
         e.cyc = cyc + 2;
         e.fd  = ((push_num % FRAME) == FRAME - 1);
         for (int f = 0; f < NF; f++) e.data[13*f +: 13] = model(f, p);
         push_num++;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         valid_in = 1'b0;
         w_load   = 1'b0;
      end
   endtask

   task automatic load_words(input int n, input bit vin);
      for (int i = 0; i < n; i++) begin
         step();
         w_load   = 1'b1;
         w_data   = 8'(tbw[i]);
         valid_in = vin;
         set_pix(9'($urandom));
      end
      step();
      w_load   = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic load_all(input bit vin);
      load_words(NW, vin);
      tb_run = 1;
      check("w_ready_after_load", longint'(w_ready), 1);
   endtask

   // Mid-cycle reset: outputs must clear without waiting for a clock edge
   task automatic do_reset();
      #2;
      rst    = 1'b1;
      sb.delete();
      push_num = 0;
      tb_run   = 0;
      last_out = '0;
      valid_in = 1'b0;
      w_load   = 1'b0;
      #1;
      check("rst_valid_out",  longint'(valid_out), 0);
      check("rst_conv_out",   longint'(conv_out), 0);
      check("rst_w_ready",    longint'(w_ready), 0);
      check("rst_frame_done", longint'(frame_done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Output monitor: pop and compare on valid_out, otherwise check hold
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (valid_out) begin
            if (sb.size() == 0) begin
               check("unexpected_valid_out", 1, 0);
            end else begin
               e = sb.pop_front();
               check("latency", cyc, e.cyc);
               for (int f = 0; f < NF; f++)
                  check($sformatf("conv_f%0d", f),
                        longint'($signed(conv_out[13*f +: 13])),
                        longint'($signed(e.data[13*f +: 13])));
               check("frame_done", longint'(frame_done), longint'(e.fd));
            end
            last_out = conv_out;
         end else begin
            check("hold", longint'(conv_out), longint'(last_out));
            if (frame_done) check("frame_done_stray", 1, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      w_load   = 1'b0;
      w_data   = '0;
      set_pix('0);
      #1;
      check("init_valid_out",  longint'(valid_out), 0);
      check("init_conv_out",   longint'(conv_out), 0);
      check("init_w_ready",    longint'(w_ready), 0);
      check("init_frame_done", longint'(frame_done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // All weights 1, biases 0; valid_in held during load must be ignored
      for (int i = 0; i < NW; i++) tbw[i] = (i % 10 == 9) ? 0 : 1;
      load_all(1'b1);
      send(9'h1FF);
      idle(3);
      // w_load in RUN must not disturb weights
      for (int i = 0; i < 3; i++) begin
         step();
         w_load = 1'b1;
         w_data = 8'h55;
      end
      idle(1);
      send(9'h1FF);
      send(9'h0F0);
      idle(4);

      // Filter 0 weights k-4, bias -3; window with pixel_0 and pixel_8 only
      do_reset();
      for (int i = 0; i < NW; i++) tbw[i] = (i % 10 == 9) ? 0 : 1;
      for (int k = 0; k < 9; k++) tbw[k] = k - 4;
      tbw[9] = -3;
      load_all(1'b0);
      send(9'h101);
      send(9'h1FF);
      idle(4);

      // Most negative case: everything -128, all pixels set
      do_reset();
      for (int i = 0; i < NW; i++) tbw[i] = -128;
      load_all(1'b0);
      send(9'h1FF);
      send(9'h000);
      idle(4);

      // Full frame plus one, random weights and windows
      do_reset();
      for (int i = 0; i < NW; i++) tbw[i] = int'($urandom_range(255)) - 128;
      load_all(1'b0);
      for (int n = 0; n < FRAME + 1; n++) send(9'($urandom));
      idle(4);
      check("drain_stream", sb.size(), 0);

      // Partial load: block must stay in LOAD and ignore windows
      do_reset();
      for (int i = 0; i < NW; i++) tbw[i] = 1;
      load_words(15, 1'b0);
      for (int n = 0; n < 10; n++) begin
         step();
         valid_in = 1'b1;
         set_pix(9'h1FF);
         check("partial_valid_out", longint'(valid_out), 0);
         check("partial_w_ready",   longint'(w_ready), 0);
      end
      idle(4);

      // Reset mid-frame with windows in flight, then reload and run a new frame
      do_reset();
      for (int i = 0; i < NW; i++) tbw[i] = int'($urandom_range(255)) - 128;
      load_all(1'b0);
      for (int n = 0; n < 102; n++) send(9'($urandom));
      idle(1);
      do_reset();
      check("post_reset_w_ready", longint'(w_ready), 0);
      for (int i = 0; i < NW; i++) tbw[i] = int'($urandom_range(255)) - 128;
      load_all(1'b0);
      for (int n = 0; n < FRAME; n++) send(9'($urandom));
      idle(4);
      check("drain_final", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
